// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the sync_fifo_ext family
package fifo_pkg;
  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;
  function automatic int fifo_ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo_ext_if.sv
// sync_fifo_ext_if: producer/consumer bus of sync_fifo_ext; master drives requests, slave is the FIFO
interface sync_fifo_ext_if import fifo_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic flush, push, pop, clr_err;
  logic [WIDTH-1:0] data_in, data_out;
  logic data_out_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [fifo_ptr_w(DEPTH)-1:0] count;
  modport master (
    output flush, push, data_in, pop, clr_err,
    input  data_out, data_out_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  flush, push, data_in, pop, clr_err,
    output data_out, data_out_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: storage array with one synchronous write port and one asynchronous read port, no reset
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO with occupancy, thresholds, sticky errors, flush
// and either first-word-fall-through or registered read output
module sync_fifo_ext import fifo_pkg::*; #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b1
) (
  input logic            clk,
  input logic            reset_n,
  sync_fifo_ext_if.slave bus
);
  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE = PW'(AE_LEVEL);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo_ext: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_af_chk
    $error("sync_fifo_ext: AF_LEVEL out of range 0..DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_ae_chk
    $error("sync_fifo_ext: AE_LEVEL out of range 0..DEPTH");
  end
  logic [PW-1:0] wr_ptr, rd_ptr, cnt;
  logic [WIDTH-1:0] rd_data;
  logic full, empty, push_ok, pop_ok;
  fifo_err_t err;
  // extra pointer MSB tells a full ring from an empty one
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  assign pop_ok  = bus.pop & ~bus.flush & ~empty;
  assign push_ok = bus.push & ~bus.flush & (~full | pop_ok);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= '0;
    end else begin
      wr_ptr        <= bus.flush ? '0 : wr_ptr + PW'(push_ok);
      rd_ptr        <= bus.flush ? '0 : rd_ptr + PW'(pop_ok);
      cnt           <= bus.flush ? '0 : cnt + PW'(push_ok) - PW'(pop_ok);
      err.overflow  <= (err.overflow & ~bus.clr_err) | (bus.push & ~bus.flush & ~push_ok);
      err.underflow <= (err.underflow & ~bus.clr_err) | (bus.pop & ~bus.flush & ~pop_ok);
    end
  assign bus.count        = cnt;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = cnt >= AF;
  assign bus.almost_empty = cnt <= AE;
  assign bus.overflow     = err.overflow;
  assign bus.underflow    = err.underflow;
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );
  if (FWFT) begin : g_fwft
    assign bus.data_out       = rd_data;
    assign bus.data_out_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout;
    logic vld;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        dout <= '0;
        vld  <= 1'b0;
      end else begin
        vld <= pop_ok;
        if (pop_ok) dout <= rd_data;
      end
    assign bus.data_out       = dout;
    assign bus.data_out_valid = vld;
  end
endmodule
